// File: rtl/reg_file_if.sv
// Register-file access bundle: one write port (din/wr_addr/wr_E) and two
// combinational read ports (A, B). The master owns addresses and write data.
interface reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  // No handshake: a write is accepted on every rising clock edge where wr_E=1
  // and reset is low; reads have no qualifier and are valid once settled.
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_E;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;

  modport master (
    output din, wr_addr, wr_E, rd_addr_a, rd_addr_b,
    input  out_a, out_b
  );

  modport slave (
    input  din, wr_addr, wr_E, rd_addr_a, rd_addr_b,
    output out_a, out_b
  );
endinterface

// File: rtl/reg_file.sv
// Eight-entry register file, one synchronous write port, two combinational
// read ports. Optional write-through forwarding: define REG_FILES_BYPASS_EN.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic      CLK,
  input  logic      CLR,
  reg_file_if.slave bus
);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_out_a;
  logic [DATA_W-1:0] w_out_b;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.wr_E) begin
      r_regs[bus.wr_addr] <= bus.din;
    end
  end

  // Forwarding is gated by CLR so outputs still read zero while in reset.
  always_comb begin
    w_out_a = r_regs[bus.rd_addr_a];
    w_out_b = r_regs[bus.rd_addr_b];
`ifdef REG_FILES_BYPASS_EN
    if (bus.wr_E && !CLR && (bus.rd_addr_a == bus.wr_addr)) begin
      w_out_a = bus.din;
    end
    if (bus.wr_E && !CLR && (bus.rd_addr_b == bus.wr_addr)) begin
      w_out_b = bus.din;
    end
`else
`endif
  end

  assign bus.out_a = w_out_a;
  assign bus.out_b = w_out_b;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, fill, write gating, dual read,
// same-address / write overlap, and asynchronous reset mid-operation.
module tb_reg_file;

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;

  logic [15:0] fill_exp [8];
  logic [15:0] bypass_pre;

  reg_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  reg_file #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    clr = 1'b0;
    bus.din = 16'h0000;
    bus.wr_addr = 3'd0;
    bus.wr_E = 1'b0;
    bus.rd_addr_a = 3'd0;
    bus.rd_addr_b = 3'd0;
    #3 clr = 1'b1;
    #1;
    vectors++;
    if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_during: out_a=%h out_b=%h expected 0000/0000", bus.out_a, bus.out_b);
    end
    #19 clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(7 - i);
      #1;
      vectors++;
      if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_sweep[%0d]: out_a=%h out_b=%h expected 0000/0000", i, bus.out_a, bus.out_b);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_E = 1'b1;
      bus.wr_addr = 3'(i);
      bus.din = 16'h0123 + 16'(50 * i);
    end
    @(negedge clk);
    bus.wr_E = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(i);
      #1;
      vectors++;
      if (bus.out_a !== fill_exp[i] || bus.out_b !== fill_exp[i]) begin
        miscompares++;
        $display("FAIL fill R%0d: out_a=%h out_b=%h expected %h", i, bus.out_a, bus.out_b, fill_exp[i]);
      end
    end
  endtask

  task automatic test_wr_gating();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_E = 1'b0;
      bus.wr_addr = 3'(i);
      bus.din = 16'hA000 + 16'(50 * i);
      bus.rd_addr_a = 3'(i);
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_a !== fill_exp[i]) begin
        miscompares++;
        $display("FAIL wr_gating R%0d: out_a=%h expected %h", i, bus.out_a, fill_exp[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_b = 3'(i);
      #1;
      vectors++;
      if (bus.out_b !== fill_exp[i]) begin
        miscompares++;
        $display("FAIL wr_gating_sweep R%0d: out_b=%h expected %h", i, bus.out_b, fill_exp[i]);
      end
    end
  endtask

  task automatic test_dual_read();
    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];
    exp_a = '{16'h0123, 16'h0187, 16'h01EB, 16'h024F};
    exp_b = '{16'h0155, 16'h01B9, 16'h021D, 16'h0281};
    for (int p = 0; p < 4; p++) begin
      bus.rd_addr_a = 3'(2 * p);
      bus.rd_addr_b = 3'(2 * p + 1);
      #1;
      vectors++;
      if (bus.out_a !== exp_a[p] || bus.out_b !== exp_b[p]) begin
        miscompares++;
        $display("FAIL dual_read pair%0d: out_a=%h out_b=%h expected %h/%h",
                 p, bus.out_a, bus.out_b, exp_a[p], exp_b[p]);
      end
    end
  endtask

  task automatic test_same_addr();
    bus.rd_addr_a = 3'd5;
    bus.rd_addr_b = 3'd5;
    #1;
    vectors++;
    if (bus.out_a !== 16'h021D || bus.out_b !== 16'h021D) begin
      miscompares++;
      $display("FAIL same_addr: out_a=%h out_b=%h expected 021D/021D", bus.out_a, bus.out_b);
    end
  endtask

  task automatic test_overlap_write();
    @(negedge clk);
    bus.rd_addr_a = 3'd5;
    bus.rd_addr_b = 3'd4;
    bus.wr_addr = 3'd5;
    bus.din = 16'hBEEF;
    bus.wr_E = 1'b1;
    #1;
`ifdef REG_FILES_BYPASS_EN
    bypass_pre = 16'hBEEF;
`else
    bypass_pre = 16'h021D;
`endif
    vectors++;
    if (bus.out_a !== bypass_pre || bus.out_b !== 16'h01EB) begin
      miscompares++;
      $display("FAIL overlap_pre_edge: out_a=%h out_b=%h expected %h/01EB", bus.out_a, bus.out_b, bypass_pre);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_a !== 16'hBEEF || bus.out_b !== 16'h01EB) begin
      miscompares++;
      $display("FAIL overlap_post_edge: out_a=%h out_b=%h expected BEEF/01EB", bus.out_a, bus.out_b);
    end
    @(negedge clk);
    bus.wr_E = 1'b0;
    bus.din = 16'h0000;
    bus.rd_addr_b = 3'd5;
    #1;
    vectors++;
    if (bus.out_a !== 16'hBEEF || bus.out_b !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL overlap_stored: out_a=%h out_b=%h expected BEEF/BEEF", bus.out_a, bus.out_b);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.wr_E = 1'b1;
    bus.wr_addr = 3'd3;
    bus.din = 16'h1234;
    bus.rd_addr_a = 3'd3;
    bus.rd_addr_b = 3'd5;
    #1 clr = 1'b1;
    #1;
    vectors++;
    if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_clear_no_edge: out_a=%h out_b=%h expected 0000/0000", bus.out_a, bus.out_b);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_clear_edge: out_a=%h out_b=%h expected 0000/0000", bus.out_a, bus.out_b);
    end
    @(negedge clk);
    bus.wr_E = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      #1;
      vectors++;
      if (bus.out_a !== 16'h0000) begin
        miscompares++;
        $display("FAIL async_clear_sweep R%0d: out_a=%h expected 0000", i, bus.out_a);
      end
    end
    // First write after reset release lands on the very next edge.
    @(negedge clk);
    bus.wr_E = 1'b1;
    bus.wr_addr = 3'd2;
    bus.din = 16'h5A5A;
    bus.rd_addr_a = 3'd2;
    bus.rd_addr_b = 3'd1;
    @(posedge clk);
    #1;
    bus.wr_E = 1'b0;
    #1;
    vectors++;
    if (bus.out_a !== 16'h5A5A || bus.out_b !== 16'h0000) begin
      miscompares++;
      $display("FAIL post_reset_write: out_a=%h out_b=%h expected 5A5A/0000", bus.out_a, bus.out_b);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    fill_exp = '{16'h0123, 16'h0155, 16'h0187, 16'h01B9,
                 16'h01EB, 16'h021D, 16'h024F, 16'h0281};
    test_reset();
    test_fill();
    test_wr_gating();
    test_dual_read();
    test_same_addr();
    test_overlap_write();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
